// File: rtl/lectura_pkg.sv
// lectura_pkg: shared types and defaults for the RTC read sequencer
// Contents: sweep state enum, default sweep/phase sizes, idle strobe level.
package lectura_pkg;
  typedef enum logic [2:0] {IDLE, SET_DIR, STB_DIR, STB_DATO, RECUP, FIN} estado_t;
  localparam int N_TRANSFER_DEF = 18;
  localparam int CICLOS_FASE_DEF = 4;
  localparam logic STB_INACTIVO = 1'b1;
endpackage

// File: rtl/contador_fase.sv
// contador_fase: loadable down-counter that times one bus phase
// Ports: clk_i, rst_n_i (async, active-low), carga_i (hold at reload value),
//        activo_i (count this cycle), tc_o (last clock of the phase).
// The counter reloads on its own terminal count, so back-to-back phases
// each last exactly CICLOS clocks.
module contador_fase
  import lectura_pkg::*;
#(
  parameter int CICLOS = CICLOS_FASE_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic carga_i,
  input  logic activo_i,
  output logic tc_o
);
  localparam int W = CICLOS > 1 ? $clog2(CICLOS) : 1;
  localparam logic [W-1:0] RECARGA = W'(CICLOS - 1);
  localparam logic [W-1:0] UNO = W'(1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc_o = activo_i && cnt_q == '0;
  always_comb cnt_d = (carga_i || tc_o) ? RECARGA : activo_i ? cnt_q - UNO : cnt_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= RECARGA;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/control_lectura_rtc.sv
// control_lectura_rtc: read-cycle sequencer for the parallel RTC bus
// Inputs : clk_i, rst_n_i (async, active-low), inicio_i (start pulse),
//          dato_in_i[7:0] (RTC read data).
// Outputs: en_o, c_s_o, cuenta_o[4:0], a_d_o (decoder control);
//          cs_n_o, wr_n_o, rd_n_o (RTC strobes); dato_o, indice_o,
//          dato_valido_o (captured byte); ocupado_o, fin_o (sweep status).
// Build option: LECTURA_AUTO_EN restarts a new sweep right after FIN.
// All outputs are registered from the next state, so they change on the
// same edge the state does and never depend combinationally on inputs.
module control_lectura_rtc
  import lectura_pkg::*;
#(
  parameter int N_TRANSFER  = N_TRANSFER_DEF,
  parameter int CICLOS_FASE = CICLOS_FASE_DEF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       inicio_i,
  input  logic [7:0] dato_in_i,
  output logic       en_o,
  output logic       c_s_o,
  output logic [4:0] cuenta_o,
  output logic       a_d_o,
  output logic       cs_n_o,
  output logic       wr_n_o,
  output logic       rd_n_o,
  output logic [7:0] dato_o,
  output logic [4:0] indice_o,
  output logic       dato_valido_o,
  output logic       ocupado_o,
  output logic       fin_o
);
  localparam logic [4:0] ULTIMA = 5'(N_TRANSFER - 1);
  estado_t estado_q, estado_d;
  logic [4:0] cuenta_q, cuenta_d, indice_q, indice_d;
  logic [7:0] dato_q, dato_d;
  logic en_q, en_d, c_s_q, c_s_d, a_d_q, a_d_d;
  logic cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic dv_q, dv_d, ocupado_q, ocupado_d, fin_q, fin_d;
  logic en_fase, tc, captura, dir_d, bus_d;

  assign en_fase = estado_q inside {SET_DIR, STB_DIR, STB_DATO, RECUP};

  contador_fase #(.CICLOS(CICLOS_FASE)) u_fase (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .carga_i (!en_fase),
    .activo_i(en_fase),
    .tc_o    (tc)
  );

  always_comb begin
    estado_d = estado_q;
    cuenta_d = cuenta_q;
    case (estado_q)
      IDLE:     if (inicio_i) estado_d = SET_DIR;
      SET_DIR:  if (tc) estado_d = STB_DIR;
      STB_DIR:  if (tc) estado_d = STB_DATO;
      STB_DATO: if (tc) estado_d = RECUP;
      RECUP:
        if (tc) begin
          if (cuenta_q == ULTIMA) estado_d = FIN;
          else begin
            cuenta_d = cuenta_q + 5'd1;
            estado_d = SET_DIR;
          end
        end
      FIN: begin
        cuenta_d = '0;
`ifdef LECTURA_AUTO_EN
        estado_d = SET_DIR;
`else
        estado_d = IDLE;
`endif
      end
      default: estado_d = IDLE;
    endcase
  end

  // Sample the RTC byte on the last clock of the read strobe, while rd_n is still low.
  always_comb begin
    captura   = estado_q == STB_DATO && tc;
    dir_d     = estado_d inside {SET_DIR, STB_DIR};
    bus_d     = estado_d inside {SET_DIR, STB_DIR, STB_DATO};
    ocupado_d = estado_d inside {SET_DIR, STB_DIR, STB_DATO, RECUP};
    en_d      = !ocupado_d;
    c_s_d     = !bus_d;
    a_d_d     = !dir_d;
    cs_n_d    = !bus_d;
    wr_n_d    = estado_d != STB_DIR;
    rd_n_d    = estado_d != STB_DATO;
    fin_d     = estado_d == FIN;
    dv_d      = captura;
    dato_d    = captura ? dato_in_i : dato_q;
    indice_d  = captura ? cuenta_q : indice_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      estado_q  <= IDLE;
      cuenta_q  <= '0;
      indice_q  <= '0;
      dato_q    <= '0;
      en_q      <= 1'b1;
      c_s_q     <= 1'b1;
      a_d_q     <= 1'b1;
      cs_n_q    <= STB_INACTIVO;
      wr_n_q    <= STB_INACTIVO;
      rd_n_q    <= STB_INACTIVO;
      dv_q      <= 1'b0;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cuenta_q  <= cuenta_d;
      indice_q  <= indice_d;
      dato_q    <= dato_d;
      en_q      <= en_d;
      c_s_q     <= c_s_d;
      a_d_q     <= a_d_d;
      cs_n_q    <= cs_n_d;
      wr_n_q    <= wr_n_d;
      rd_n_q    <= rd_n_d;
      dv_q      <= dv_d;
      ocupado_q <= ocupado_d;
      fin_q     <= fin_d;
    end

  assign en_o          = en_q;
  assign c_s_o         = c_s_q;
  assign cuenta_o      = cuenta_q;
  assign a_d_o         = a_d_q;
  assign cs_n_o        = cs_n_q;
  assign wr_n_o        = wr_n_q;
  assign rd_n_o        = rd_n_q;
  assign dato_o        = dato_q;
  assign indice_o      = indice_q;
  assign dato_valido_o = dv_q;
  assign ocupado_o     = ocupado_q;
  assign fin_o         = fin_q;
endmodule
